// File: rtl/swseq_pkg.sv
// Shared types and constants for the switch sequence checker: FSM states,
// 4-bit pattern encoding {invalid, sw3, sw2, sw1} and 7-segment glyphs.
package swseq_pkg;

   typedef enum logic [1:0] {StIdle, StTrack, StError} state_e;

   localparam logic [3:0] PAT_S0      = 4'b0000;
   localparam logic [3:0] PAT_S1      = 4'b0100;
   localparam logic [3:0] PAT_S2      = 4'b0110;
   localparam logic [3:0] PAT_S3      = 4'b0111;
   localparam logic [3:0] PAT_S4      = 4'b0011;
   localparam logic [3:0] PAT_S5      = 4'b0001;
   localparam logic [3:0] PAT_INVALID = 4'b1000;
   // Never produced by decode, so nothing can match it.
   localparam logic [3:0] PAT_NONE    = 4'b1111;

   localparam logic [31:0] CODE_ILLEGAL = 32'd4;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_E     = 7'h06;

   function automatic logic [3:0] seq_pat(input logic [2:0] idx);
      case (idx)
         3'd0:    return PAT_S0;
         3'd1:    return PAT_S1;
         3'd2:    return PAT_S2;
         3'd3:    return PAT_S3;
         3'd4:    return PAT_S4;
         3'd5:    return PAT_S5;
         default: return PAT_NONE;
      endcase
   endfunction

   function automatic logic [3:0] decode(input logic [31:0] n3, input logic [31:0] n2,
                                         input logic [31:0] n1);
      logic w_ok;
      w_ok = (n3 == 32'd3 || n3 == 32'd0) && (n2 == 32'd2 || n2 == 32'd0) &&
             (n1 == 32'd1 || n1 == 32'd0);
      if (!w_ok) return PAT_INVALID;
      return {1'b0, n3 == 32'd3, n2 == 32'd2, n1 == 32'd1};
   endfunction

   // Active-low gfedcba hex glyphs.
   function automatic logic [6:0] seg_hex(input logic [3:0] v);
      case (v)
         4'h0:    return 7'h40;
         4'h1:    return 7'h79;
         4'h2:    return 7'h24;
         4'h3:    return 7'h30;
         4'h4:    return 7'h19;
         4'h5:    return 7'h12;
         4'h6:    return 7'h02;
         4'h7:    return 7'h78;
         4'h8:    return 7'h00;
         4'h9:    return 7'h10;
         4'hA:    return 7'h08;
         4'hB:    return 7'h03;
         4'hC:    return 7'h46;
         4'hD:    return 7'h21;
         4'hE:    return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

endpackage

// File: rtl/swseq_stable_filter.sv
// Registers the decoded pattern, counts consecutive equal samples and strobes
// once when a pattern different from the last accepted one has held STABLE_CYCLES.
module swseq_stable_filter
   import swseq_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [3:0] i_pat,
   output logic       o_acc,
   output logic [3:0] o_acc_pat
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   logic [3:0]       r_pat;
   logic [CNT_W-1:0] r_cnt;
   logic             r_acc;
   logic [3:0]       r_acc_pat;
   logic             r_acc_vld;

   logic [CNT_W-1:0] w_cnt;
   logic             w_acc;

   // r_cnt == 0 after reset, so the first sample always starts a fresh run.
   always_comb begin
      w_cnt = CNT_W'(1);
      if (i_pat == r_pat) begin
         w_cnt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
      end
      w_acc = (w_cnt == CNT_MAX) && (!r_acc_vld || i_pat != r_acc_pat);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pat     <= PAT_S0;
         r_cnt     <= '0;
         r_acc     <= 1'b0;
         r_acc_pat <= PAT_S0;
         r_acc_vld <= 1'b0;
      end else begin
         r_pat <= i_pat;
         r_cnt <= w_cnt;
         r_acc <= w_acc;
         if (w_acc) begin
            r_acc_pat <= i_pat;
            r_acc_vld <= 1'b1;
         end
      end
   end

   assign o_acc     = r_acc;
   assign o_acc_pat = r_acc_pat;

endmodule

// File: rtl/switch_sequence_checker.sv
// Debounces switch codes and tracks the 000-100-110-111-011-001 cycle.
// Optional 7-segment outputs are enabled with `define SWSEQ_SEVENSEG_EN.
module switch_sequence_checker
   import swseq_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned LAP_W         = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [31:0]      i_n3,
   input  logic [31:0]      i_n2,
   input  logic [31:0]      i_n1,
   output logic [2:0]       o_pos,
   output logic [LAP_W-1:0] o_lap_cnt,
   output logic             o_lap_done,
   output logic             o_err,
   output logic             o_invalid
`ifdef SWSEQ_SEVENSEG_EN
   ,
   output logic [6:0]       o_seg_pos,
   output logic [6:0]       o_seg_lap
`endif
);

   state_e           r_state;
   logic [2:0]       r_pos;
   logic [LAP_W-1:0] r_lap;
   logic             r_lap_done;
   logic             r_err;
   logic             r_invalid;

   logic [3:0]       w_pat;
   logic             w_acc;
   logic [3:0]       w_acc_pat;
   logic [2:0]       w_pos_next;

   assign w_pat      = decode(i_n3, i_n2, i_n1);
   assign w_pos_next = (r_pos == 3'd5) ? 3'd0 : r_pos + 3'd1;

   swseq_stable_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_pat    (w_pat),
      .o_acc    (w_acc),
      .o_acc_pat(w_acc_pat)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_invalid <= 1'b0;
      end else begin
         r_invalid <= (w_pat == PAT_INVALID);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_pos      <= 3'd0;
         r_lap      <= '0;
         r_lap_done <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_lap_done <= 1'b0;
         if (w_acc) begin
            unique case (r_state)
               StIdle, StError: begin
                  if (w_acc_pat == PAT_S0) begin
                     r_state <= StTrack;
                     r_pos   <= 3'd0;
                     r_err   <= 1'b0;
                  end
               end
               StTrack: begin
                  if (w_acc_pat == seq_pat(w_pos_next)) begin
                     r_pos <= w_pos_next;
                     if (r_pos == 3'd5) begin
                        r_lap_done <= 1'b1;
                        if (r_lap != '1) r_lap <= r_lap + 1'b1;
                     end
                  end else begin
                     r_state <= StError;
                     r_err   <= 1'b1;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign o_pos      = r_pos;
   assign o_lap_cnt  = r_lap;
   assign o_lap_done = r_lap_done;
   assign o_err      = r_err;
   assign o_invalid  = r_invalid;

`ifdef SWSEQ_SEVENSEG_EN
   logic [LAP_W+3:0] w_lap_wide;
   logic [6:0]       r_seg_pos;
   logic [6:0]       r_seg_lap;

   assign w_lap_wide = {4'b0000, r_lap};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_seg_pos <= SEG_BLANK;
         r_seg_lap <= SEG_BLANK;
      end else begin
         r_seg_pos <= seg_hex({1'b0, r_pos});
         r_seg_lap <= r_err ? SEG_E : seg_hex(w_lap_wide[3:0]);
      end
   end

   assign o_seg_pos = r_seg_pos;
   assign o_seg_lap = r_seg_lap;
`endif

endmodule

// File: tb/tb_switch_sequence_checker.sv
// Directed bench for switch_sequence_checker: a sample-history model of the
// stability rule and lap sequence is checked against the DUT every cycle.
module tb_switch_sequence_checker;

   localparam int S   = 4;
   localparam int LW  = 4;
   localparam int MAX = (1 << LW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   n3, n2, n1;
   logic [2:0]    pos;
   logic [LW-1:0] lap_cnt;
   logic          lap_done, err, invalid;

   always #5 clk = ~clk;

   switch_sequence_checker #(
      .STABLE_CYCLES(S),
      .LAP_W        (LW)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_n3      (n3),
      .i_n2      (n2),
      .i_n1      (n1),
      .o_pos     (pos),
      .o_lap_cnt (lap_cnt),
      .o_lap_done(lap_done),
      .o_err     (err),
      .o_invalid (invalid)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int ld_cnt = 0;
   bit started = 0;

   int seq [6] = '{0, 4, 6, 7, 3, 1};
   int hist [$];
   int m_acc_pat, m_st, m_pos, m_lap, pend_pat, d;
   bit m_acc_vld, m_ld, m_err, m_inv, pend, stable;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int dec_pat(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c);
      if ((a == 3 || a == 0) && (b == 2 || b == 0) && (c == 1 || c == 0))
         return (a == 3 ? 4 : 0) + (b == 2 ? 2 : 0) + (c == 1 ? 1 : 0);
      return -1;
   endfunction

   // Lap rules applied to one accepted pattern: 0 = idle, 1 = track, 2 = error.
   task automatic step(input int p);
      if (m_st != 1) begin
         if (p == 0) begin
            m_st = 1; m_pos = 0; m_err = 0;
         end
      end else if (p == seq[(m_pos + 1) % 6]) begin
         if (m_pos == 5) begin
            m_lap = (m_lap < MAX) ? m_lap + 1 : MAX;
            m_ld  = 1;
         end
         m_pos = (m_pos + 1) % 6;
      end else begin
         m_st = 2; m_err = 1;
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         hist.delete();
         m_acc_vld = 0; m_acc_pat = 0; pend = 0;
         m_st = 0; m_pos = 0; m_lap = 0; m_ld = 0; m_err = 0; m_inv = 0;
         started = 1;
      end else begin
         m_ld = 0;
         if (pend) step(pend_pat);
         pend  = 0;
         d     = dec_pat(n3, n2, n1);
         m_inv = (d < 0);
         hist.push_back(d);
         if (hist.size() > S) void'(hist.pop_front());
         stable = (hist.size() == S);
         foreach (hist[i]) if (hist[i] != d) stable = 0;
         if (stable && (!m_acc_vld || d != m_acc_pat)) begin
            pend = 1; pend_pat = d; m_acc_vld = 1; m_acc_pat = d;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("cyc_pos", {29'd0, pos}, m_pos);
         chk("cyc_lap", {{(32-LW){1'b0}}, lap_cnt}, m_lap);
         chk("cyc_lap_done", {31'd0, lap_done}, {31'd0, m_ld});
         chk("cyc_err", {31'd0, err}, {31'd0, m_err});
         chk("cyc_invalid", {31'd0, invalid}, {31'd0, m_inv});
         if (lap_done) ld_cnt++;
      end
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      n3 = a; n2 = b; n1 = c;
   endtask

   task automatic hold(input logic [2:0] p, input int cyc);
      drive(p[2] ? 32'd3 : 32'd0, p[1] ? 32'd2 : 32'd0, p[0] ? 32'd1 : 32'd0);
      repeat (cyc) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic lap();
      hold(3'b100, 6); hold(3'b110, 6); hold(3'b111, 6);
      hold(3'b011, 6); hold(3'b001, 6); hold(3'b000, 6);
   endtask

   int ld0;

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pos", {29'd0, pos}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_lap", {{(32-LW){1'b0}}, lap_cnt}, 0);
      chk("rst_invalid", {31'd0, invalid}, 0);
      rst_n = 1'b1;

      // One full lap
      hold(3'b000, 6); chk("lap_p0", {29'd0, pos}, 0);
      hold(3'b100, 6); chk("lap_p1", {29'd0, pos}, 1);
      hold(3'b110, 6); chk("lap_p2", {29'd0, pos}, 2);
      hold(3'b111, 6); chk("lap_p3", {29'd0, pos}, 3);
      hold(3'b011, 6); chk("lap_p4", {29'd0, pos}, 4);
      hold(3'b001, 6); chk("lap_p5", {29'd0, pos}, 5);
      ld0 = ld_cnt;
      hold(3'b000, 6);
      chk("lap_wrap_pos", {29'd0, pos}, 0);
      chk("lap_cnt1", {{(32-LW){1'b0}}, lap_cnt}, 1);
      chk("lap_done_once", ld_cnt - ld0, 1);
      chk("model_lap1", m_lap, 1);
      chk("lap_err0", {31'd0, err}, 0);

      // Skip step -> error, then recover on 000
      hold(3'b100, 6); chk("skip_p1", {29'd0, pos}, 1);
      hold(3'b111, 6);
      chk("skip_err", {31'd0, err}, 1);
      chk("skip_pos_hold", {29'd0, pos}, 1);
      chk("model_err", {31'd0, m_err}, 1);
      hold(3'b000, 6);
      chk("recover_err", {31'd0, err}, 0);
      chk("recover_pos", {29'd0, pos}, 0);
      chk("recover_lap", {{(32-LW){1'b0}}, lap_cnt}, 1);

      // Illegal codes while tracking
      drive(4, 4, 4);
      @(posedge clk); #1;
      chk("inv_flag", {31'd0, invalid}, 1);
      chk("inv_err_early", {31'd0, err}, 0);
      repeat (5) begin @(posedge clk); #1; end
      chk("inv_err", {31'd0, err}, 1);
      hold(3'b000, 6);
      drive(3, 2, 5);
      @(posedge clk); #1;
      chk("inv_odd_code", {31'd0, invalid}, 1);
      hold(3'b000, 6);
      chk("inv_glitch_err", {31'd0, err}, 0);
      chk("inv_glitch_inv", {31'd0, invalid}, 0);

      // Short pulse is filtered
      hold(3'b100, S - 1);
      hold(3'b000, 6);
      chk("glitch_pos", {29'd0, pos}, 0);
      chk("glitch_err", {31'd0, err}, 0);

      // Saturation over 16 laps from a fresh reset
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("sat_rst_lap", {{(32-LW){1'b0}}, lap_cnt}, 0);
      hold(3'b000, 6);
      ld0 = ld_cnt;
      repeat (15) lap();
      chk("sat_lap15", {{(32-LW){1'b0}}, lap_cnt}, 15);
      lap();
      chk("sat_lap16", {{(32-LW){1'b0}}, lap_cnt}, 15);
      chk("sat_ld16", ld_cnt - ld0, 16);
      chk("model_sat", m_lap, 15);

      // Reset mid-lap at pos 3, then requalification
      hold(3'b100, 6); hold(3'b110, 6); hold(3'b111, 6);
      chk("mid_p3", {29'd0, pos}, 3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_pos", {29'd0, pos}, 0);
      chk("mid_rst_lap", {{(32-LW){1'b0}}, lap_cnt}, 0);
      chk("mid_rst_err", {31'd0, err}, 0);
      chk("mid_rst_ld", {31'd0, lap_done}, 0);
      chk("mid_rst_inv", {31'd0, invalid}, 0);
      rst_n = 1'b1;
      hold(3'b111, 10);
      chk("idle_hold111", {29'd0, pos}, 0);
      hold(3'b000, S - 1);
      hold(3'b100, 6);
      chk("idle_ign_pos", {29'd0, pos}, 0);
      chk("idle_ign_err", {31'd0, err}, 0);
      hold(3'b000, 6);
      hold(3'b100, 6);
      chk("idle_enter_p1", {29'd0, pos}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
